serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Bit-serial N-bit subtractor: accepts two operands and a borrow-in through a valid/ready handshake, then streams them LSB-first through a single full-subtractor bit-slice, one bit per clock, with the borrow held in a flip-flop.
- Returns difference, borrow-out and signed-overflow through a second valid/ready handshake.
- Sits directly upstream of the full-subtractor cell: it sequences operand bits into the cell and consumes the cell's difference/borrow each cycle.
- Used where area matters more than throughput.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in (chaining wider subtractions)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH
- borrow_out  out  1  unsigned borrow (a < b + bin)
- overflow  out  1  two's-complement overflow of a − b − bin

## Operation
FSM states:
- IDLE: in_ready=1. On in_valid at a clock edge: load a→shift_a, b→shift_b, bin→borrow_q, clear count and diff shift register, go to SHIFT.
- SHIFT: each edge, the bit-slice computes on shift_a[0], shift_b[0], borrow_q.
  - Its difference shifts into the diff register's MSB end.
  - Its borrow-out is written to borrow_q.
  - shift_a and shift_b shift right; count increments.
  - After the WIDTH-th shift edge, go to DONE.
- DONE: out_valid=1; diff, borrow_out (=borrow_q) and overflow are stable. On out_ready, go to IDLE.

Rules:
- overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), computed from latched a[MSB] and b[MSB].
- in_ready is 0 in SHIFT and DONE; in_valid is ignored there and operands are not sampled.
- Outputs hold while out_valid=1 and out_ready=0, for any number of cycles.
- Counter width: $clog2(WIDTH+1); it never wraps within an operation.

## Timing
- Reset (rst=1 at an edge, any state, including mid-SHIFT): state→IDLE, in_ready=1 after the edge, out_valid=0, diff=0, borrow_out=0, overflow=0, counter=0. The in-flight operation is discarded and no result is emitted.
- rst has priority over in_valid and out_ready on the same edge.
- Accept edge = edge E with in_valid & in_ready.
- SHIFT occupies edges E+1 … E+WIDTH. out_valid rises after edge E+WIDTH, a latency of WIDTH cycles.
- Result handshake edge H (out_valid & out_ready): IDLE after H. The earliest next accept is edge H+1, so minimum throughput is one operation per WIDTH+2 cycles.
- out_ready held high in advance: the handshake completes on the first DONE cycle.
- Bit-slice path is combinational between registers: one full-subtractor delay plus register setup.

## Structure
- Shared package: state encoding type (IDLE/SHIFT/DONE) and the default WIDTH constant.
- Sub-module: one instance of the team's existing full-subtractor cell, full_subtractor_using_half_subtractors (ports A, B, Bin, difference, borrow_out), as the bit-slice.
- All sequencing, shift registers and handshake logic live in serial_subtractor.

## Test plan
Run all scenarios with WIDTH=8.
- a=0x05, b=0x03, bin=0 → diff=0x02, borrow_out=0, overflow=0; out_valid exactly 8 cycles after accept.
- a=0x03, b=0x05, bin=0 → diff=0xFE, borrow_out=1, overflow=0.
- a=0x00, b=0x00, bin=1 → diff=0xFF, borrow_out=1. Then a=0x80, b=0x01, bin=0 → diff=0x7F, borrow_out=0, overflow=1.
- Backpressure and ignored request: hold out_ready=0 for 5 cycles in DONE.
  - Required: outputs stable, in_ready=0; a new in_valid with a=0xAA is ignored.
  - On release: IDLE next cycle, and the following accept yields the correct result.
- Mid-operation reset:
  - Accept a=0x55, b=0x11, assert rst at the 4th SHIFT edge.
  - Required: out_valid=0, all outputs 0, in_ready=1 after that edge; a fresh a=0x10, b=0x01 gives diff=0x0F.
- Random back-to-back: 1000 random a/b/bin with random out_ready stalls; compare every result against the {borrow, diff} = a − b − bin reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
// No ports; imported by serial_subtractor.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;   // waiting for operands
   localparam state_t ST_SHIFT = 2'd1;   // one bit per clock through the cell
   localparam state_t ST_DONE  = 2'd2;   // result held until consumer takes it

endpackage

// File: rtl/full_subtractor_using_half_subtractors.sv
// Single-bit full subtractor built from two half-subtractor stages.
// Ports: A (minuend bit), B (subtrahend bit), Bin (borrow-in),
//        difference = A - B - Bin (mod 2), borrow_out = borrow of that bit.
module full_subtractor_using_half_subtractors (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic difference,
   output logic borrow_out
);

   logic w_hs1_diff;
   logic w_hs1_borrow;
   logic w_hs2_borrow;

   // First half subtractor: A - B
   assign w_hs1_diff   = A ^ B;
   assign w_hs1_borrow = ~A & B;

   // Second half subtractor: (A - B) - Bin
   assign difference   = w_hs1_diff ^ Bin;
   assign w_hs2_borrow = ~w_hs1_diff & Bin;

   // At most one stage can borrow, so OR merges them
   assign borrow_out   = w_hs1_borrow | w_hs2_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first through one cell.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a, b, bin operand
//        handshake; out_valid/out_ready + diff, borrow_out, overflow result.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int               CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   state_t            r_state;
   logic [WIDTH-1:0]  r_shift_a;
   logic [WIDTH-1:0]  r_shift_b;
   logic [WIDTH-1:0]  r_diff;
   logic              r_borrow;
   logic [CW-1:0]     r_cnt;
   logic              r_a_msb;
   logic              r_b_msb;

   logic              w_cell_diff;
   logic              w_cell_borrow;

   full_subtractor_using_half_subtractors u_cell (
      .A          (r_shift_a[0]),
      .B          (r_shift_b[0]),
      .Bin        (r_borrow),
      .difference (w_cell_diff),
      .borrow_out (w_cell_borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift_a <= '0;
         r_shift_b <= '0;
         r_diff    <= '0;
         r_borrow  <= 1'b0;
         r_cnt     <= '0;
         r_a_msb   <= 1'b0;
         r_b_msb   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_shift_a <= a;
                  r_shift_b <= b;
                  r_borrow  <= bin;
                  r_diff    <= '0;
                  r_cnt     <= '0;
                  // Sign bits are consumed by the shifter, keep them for overflow
                  r_a_msb   <= a[WIDTH-1];
                  r_b_msb   <= b[WIDTH-1];
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Difference bits enter at the MSB so after WIDTH shifts bit 0
               // sits at the LSB.
               r_diff    <= {w_cell_diff, r_diff[WIDTH-1:1]};
               r_borrow  <= w_cell_borrow;
               r_shift_a <= {1'b0, r_shift_a[WIDTH-1:1]};
               r_shift_b <= {1'b0, r_shift_b[WIDTH-1:1]};
               r_cnt     <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign out_valid  = (r_state == ST_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;
   // Operands of differing sign whose result sign differs from the minuend
   assign overflow   = (r_a_msb ^ r_b_msb) & (r_diff[WIDTH-1] ^ r_a_msb);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .bin        (bin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic on the operands.
   task automatic ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rbin,
                            output logic [7:0] rd, output logic rbo, output logic rov);
      int r;
      logic [7:0] d;
      r   = int'(ra) - int'(rb) - int'(rbin);
      d   = 8'(r);
      rd  = d;
      rbo = (r < 0);
      rov = (ra[7] != rb[7]) && (d[7] != ra[7]);
   endtask

   // One full operation: accept, wait for result, optional stall, handshake.
   task automatic run_op(input string tag,
                         input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int stall, input bit pre, input bit poke);
      int n;
      in_valid  = 1'b1;
      a         = ta;
      b         = tb_;
      bin       = tbin;
      out_ready = pre;
      step();                       // accept edge E
      in_valid  = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, 8);
      for (int k = 0; k < stall; k++) begin
         if (poke) begin
            in_valid = 1'b1;
            a        = 8'hAA;
         end
         chk({tag, "_stall_valid"}, out_valid, 1'b1);
         chk({tag, "_stall_inrdy"}, in_ready, 1'b0);
         chk({tag, "_stall_diff"}, diff, ed);
         step();
      end
      in_valid = 1'b0;
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_borrow"}, borrow_out, eb);
      chk({tag, "_ovf"}, overflow, eo);
      out_ready = 1'b1;
      step();                       // handshake edge H
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, out_valid, 1'b0);
      chk({tag, "_idle_inrdy"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] ra, rb, rd;
      logic       rbin, rbo, rov, pre;
      int         stall;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      step();
      step();
      rst = 1'b0;

      chk("rst_inrdy", in_ready, 1'b1);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_diff", diff, 8'h00);
      chk("rst_borrow", borrow_out, 1'b0);
      chk("rst_ovf", overflow, 1'b0);

      run_op("d05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run_op("d03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      run_op("d00bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      run_op("d80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      // Backpressure with ignored request, then a fresh op right after
      run_op("bp", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 5, 1'b0, 1'b1);
      run_op("bp_next", 8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Reset on the 4th SHIFT edge discards the operation
      in_valid = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_inrdy", in_ready, 1'b1);
      chk("mrst_diff", diff, 8'h00);
      chk("mrst_borrow", borrow_out, 1'b0);
      chk("mrst_ovf", overflow, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("mrst_no_result", out_valid, 1'b0);
      end
      run_op("mrst_next", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Random operations with random stalls against the reference model
      for (int i = 0; i < 1000; i++) begin
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         rbin  = 1'($urandom);
         pre   = ($urandom_range(0, 3) == 0);
         stall = pre ? 0 : int'($urandom_range(0, 3));
         ref_model(ra, rb, rbin, rd, rbo, rov);
         run_op("rand", ra, rb, rbin, rd, rbo, rov, stall, pre, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
